// File: rtl/alu_pipelined_pkg.sv
// alu_pipelined_pkg: op encodings, FSM states and op-class helpers shared by the pipelined ALU
package alu_pipelined_pkg;
  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SLL    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_SLT    = 5'd8,
    ALU_SLTU   = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17
  } alu_op_t;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  function automatic logic is_muldiv(alu_op_t op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction
  function automatic logic is_div(alu_op_t op);
    return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative unsigned shift-add multiplier / restoring divider
//   start/is_div/a/b : load operands (magnitudes); a*b or a/b
//   done             : high during the last iteration cycle
//   hi/lo            : product {hi,lo}, or remainder (hi) and quotient (lo)
module alu_muldiv_iter #(
  parameter int XLEN = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            start,
  input  logic            is_div,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  localparam int K = BITS_PER_CYCLE;
  localparam int N = XLEN / K;
  localparam int CW = $clog2(N);
  logic [CW-1:0] cnt;
  logic active, div_r, ge;
  logic [XLEN-1:0] opnd, d_r, d_q;
  logic [XLEN+K-1:0] m_sum;
  logic [XLEN:0] d_t;
  assign done = active && cnt == '0;
  // K multiplier bits per step; the accumulator cannot exceed XLEN+K bits
  assign m_sum = {{K{1'b0}}, hi} + {{K{1'b0}}, opnd} * (XLEN+K)'(lo[K-1:0]);
  // K restoring-division steps: remainder in hi, dividend shifts out of lo as quotient shifts in
  always_comb begin
    d_r = hi;
    d_q = lo;
    d_t = '0;
    ge = 1'b0;
    for (int i = 0; i < K; i++) begin
      d_t = {d_r, d_q[XLEN-1]};
      ge = d_t >= {1'b0, opnd};
      d_t = ge ? d_t - {1'b0, opnd} : d_t;
      d_q = {d_q[XLEN-2:0], ge};
      d_r = d_t[XLEN-1:0];
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      active <= 1'b0;
      div_r <= 1'b0;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      opnd <= '0;
    end else if (flush) begin
      active <= 1'b0;
    end else if (start) begin
      active <= 1'b1;
      div_r <= is_div;
      cnt <= CW'(N - 1);
      hi <= '0;
      lo <= is_div ? a : b;
      opnd <= is_div ? b : a;
    end else if (active) begin
      active <= cnt != '0;
      cnt <= cnt - CW'(1);
      hi <= div_r ? d_r : m_sum[XLEN+K-1:K];
      lo <= div_r ? d_q : {m_sum[K-1:0], lo[XLEN-1:K]};
    end
endmodule

// File: rtl/alu_pipelined.sv
// alu_pipelined: EX-stage ALU with single-cycle ops, iterative RV32M mul/div and ready/valid on both sides
//   in_valid/in_ready/control/left_operand/right_operand : op request
//   out_valid/out_ready/result/zero_flag                 : registered result
//   flush : kill in-flight op and pending result; busy : iterative unit active
module alu_pipelined
  import alu_pipelined_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      control,
  input  logic [XLEN-1:0] left_operand,
  input  logic [XLEN-1:0] right_operand,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero_flag,
  output logic            busy
);
  localparam int SW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  alu_op_t op, op_r;
  state_t state, state_n;
  logic [XLEN-1:0] a, b, single, fixed, q_f, r_f, a_mag, b_mag, hi, lo;
  logic [2*XLEN-1:0] prod;
  logic a_neg, b_neg, a_neg_r, b_neg_r, div0, ovf, iter, accept, out_free, done;
  assign a = left_operand;
  assign b = right_operand;
  assign op = alu_op_t'(control);
  assign out_free = !out_valid || out_ready;
  assign in_ready = state == S_IDLE && out_free;
  assign accept = in_valid && in_ready && !flush;
  assign busy = state != S_IDLE;
  assign div0 = b == '0;
  assign ovf = a == MIN && b == '1;
  // divide-by-zero and signed overflow are answered by the single-cycle path
  assign iter = is_muldiv(op) && !(is_div(op) && div0) && !((op == ALU_DIV || op == ALU_REM) && ovf);
  assign a_neg = op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM} && a[XLEN-1];
  assign b_neg = op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM} && b[XLEN-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  always_comb begin
    single = a + b;
    case (op)
      ALU_SUB:  single = a - b;
      ALU_AND:  single = a & b;
      ALU_OR:   single = a | b;
      ALU_XOR:  single = a ^ b;
      ALU_SLL:  single = a << b[SW-1:0];
      ALU_SRL:  single = a >> b[SW-1:0];
      ALU_SRA:  single = $unsigned($signed(a) >>> b[SW-1:0]);
      ALU_SLT:  single = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: single = {{(XLEN-1){1'b0}}, a < b};
      ALU_DIV:  single = div0 ? '1 : MIN;
      ALU_DIVU: single = '1;
      ALU_REM:  single = div0 ? a : '0;
      ALU_REMU: single = a;
      default:  ;
    endcase
  end
  alu_muldiv_iter #(.XLEN(XLEN), .BITS_PER_CYCLE(BITS_PER_CYCLE)) u_iter (
    .clk(clk),
    .reset_n(reset_n),
    .flush(flush),
    .start(accept && iter),
    .is_div(is_div(op)),
    .a(a_mag),
    .b(b_mag),
    .done(done),
    .hi(hi),
    .lo(lo)
  );
  // sign fix-up of the unsigned magnitude result; quotient/product sign is a^b, remainder follows the dividend
  assign prod = (a_neg_r ^ b_neg_r) ? -{hi, lo} : {hi, lo};
  assign q_f = (a_neg_r ^ b_neg_r) ? -lo : lo;
  assign r_f = a_neg_r ? -hi : hi;
  assign fixed = op_r == ALU_MUL ? prod[XLEN-1:0] :
                 op_r inside {ALU_MULH, ALU_MULHSU, ALU_MULHU} ? prod[2*XLEN-1:XLEN] :
                 op_r inside {ALU_DIV, ALU_DIVU} ? q_f : r_f;
  always_comb begin
    state_n = flush ? S_IDLE :
              state == S_IDLE ? (accept && iter ? S_BUSY : S_IDLE) :
              state == S_BUSY ? (done ? S_DONE : S_BUSY) :
              out_free ? S_IDLE : S_DONE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      out_valid <= 1'b0;
      result <= '0;
      zero_flag <= 1'b0;
      op_r <= ALU_ADD;
      a_neg_r <= 1'b0;
      b_neg_r <= 1'b0;
    end else begin
      if (accept) begin
        op_r <= op;
        a_neg_r <= a_neg;
        b_neg_r <= b_neg;
      end
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept && !iter) begin
        out_valid <= 1'b1;
        result <= single;
        zero_flag <= single == '0;
      end else if (state == S_DONE && out_free) begin
        out_valid <= 1'b1;
        result <= fixed;
        zero_flag <= fixed == '0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_alu_pipelined.sv
// tb_alu_pipelined: randomized scoreboard bench for alu_pipelined against a 64-bit arithmetic reference model
module tb_alu_pipelined;
  import alu_pipelined_pkg::*;
  localparam logic [31:0] MIN = 32'h8000_0000;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;
  logic clk = 1'b0, reset_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, zero_flag, busy;
  logic [4:0] control = 5'd0;
  logic [31:0] left_operand = '0, right_operand = '0, result;
  int cyc = 0, asserts = 0, fails = 0;
  bit seen = 0;
  typedef struct { logic [31:0] val; int due; } exp_t;
  exp_t sb[$];

  alu_pipelined #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .control(control),
    .left_operand(left_operand),
    .right_operand(right_operand),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .zero_flag(zero_flag),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb2;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb2 = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      ALU_SUB:    return a - b;
      ALU_AND:    return a & b;
      ALU_OR:     return a | b;
      ALU_XOR:    return a ^ b;
      ALU_SLL:    return a << b[4:0];
      ALU_SRL:    return a >> b[4:0];
      ALU_SRA:    return 32'(sa >>> b[4:0]);
      ALU_SLT:    return {31'b0, sa < sb2};
      ALU_SLTU:   return {31'b0, ua < ub};
      ALU_MUL:    return 32'(ua * ub);
      ALU_MULH:   return 32'((sa * sb2) >>> 32);
      ALU_MULHSU: return 32'((sa * longint'(ub)) >>> 32);
      ALU_MULHU:  return 32'((ua * ub) >> 32);
      ALU_DIV:    return b == 0 ? ONES : 32'(sa / sb2);
      ALU_DIVU:   return b == 0 ? ONES : a / b;
      ALU_REM:    return b == 0 ? a : 32'(sa % sb2);
      ALU_REMU:   return b == 0 ? a : a % b;
      default:    return a + b;
    endcase
  endfunction

  function automatic int lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bit md, special;
    md = op >= ALU_MUL && op <= ALU_REMU;
    special = (op >= ALU_DIV && op <= ALU_REMU && b == 0) ||
              ((op == ALU_DIV || op == ALU_REM) && a == MIN && b == ONES);
    return md && !special ? 34 : 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return ONES;
      2: return MIN;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      seen = 0;
    end else if (out_valid && sb.size() == 0) begin
      check("spurious out_valid", 32'(out_valid), 32'd0);
    end else if (out_valid) begin
      if (!seen) check("latency", cyc, sb[0].due);
      seen = 1;
      if (out_ready) begin
        check("result", result, sb[0].val);
        check("zero_flag", 32'(zero_flag), 32'(sb[0].val == 0));
        sb.delete(0);
        seen = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input bit push, output int waited);
    control = op;
    left_operand = a;
    right_operand = b;
    in_valid = 1'b1;
    waited = 0;
    #2;
    while (!in_ready && waited < 100) begin
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      #2;
      waited++;
    end
    if (!in_ready) check("accept timeout", 32'(in_ready), 32'd1);
    else if (push) sb.push_back('{model(op, a, b), cyc + lat(op, a, b)});
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int rdy);
    rdy = 0;
    for (int n = 0; n < 100 && !out_valid; n++) begin
      #2;
      if (in_ready) rdy++;
      @(posedge clk);
      #2;
    end
    check("result timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " result"}, result, 32'd0);
    check({tag, " zero_flag"}, 32'(zero_flag), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int w, r;
    tick(3);
    check_reset_state("reset");
    reset_n = 1'b1;
    tick(1);
    // back-to-back single-cycle ops
    issue(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 1, w);
    check("t1 add waited", w, 0);
    issue(ALU_SUB, 32'd5, 32'd5, 1, w);
    check("t1 sub waited", w, 0);
    // shifts and compares
    issue(ALU_SRA, MIN, 32'd31, 1, w);
    issue(ALU_SLL, 32'd1, 32'd33, 1, w);
    issue(ALU_SLTU, 32'd1, ONES, 1, w);
    issue(ALU_SLT, 32'd1, ONES, 1, w);
    // iterative multiplies
    issue(ALU_MULH, -32'sd3, 32'd7, 1, w);
    check("t3 busy", 32'(busy), 32'd1);
    wait_out(r);
    check("t3 mulh in_ready low", r, 0);
    issue(ALU_MULHU, ONES, ONES, 1, w);
    wait_out(r);
    check("t3 mulhu in_ready low", r, 0);
    // divide special cases on the single-cycle path
    issue(ALU_DIV, 32'd7, 32'd0, 1, w);
    issue(ALU_REMU, 32'd9, 32'd0, 1, w);
    check("t4 remu waited", w, 0);
    issue(ALU_DIV, MIN, ONES, 1, w);
    check("t4 div ovf waited", w, 0);
    issue(ALU_REM, MIN, ONES, 1, w);
    check("t4 rem ovf waited", w, 0);
    // signed divide, then flush mid-BUSY
    issue(ALU_DIV, -32'sd7, 32'd2, 1, w);
    wait_out(r);
    issue(ALU_REM, -32'sd7, 32'd2, 1, w);
    wait_out(r);
    issue(ALU_DIV, -32'sd7, 32'd2, 0, w);
    tick(9);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check("t5 busy after flush", 32'(busy), 32'd0);
    check("t5 in_ready after flush", 32'(in_ready), 32'd1);
    check("t5 out_valid after flush", 32'(out_valid), 32'd0);
    tick(40);
    // op offered together with flush is dropped
    control = ALU_ADD;
    left_operand = 32'd1;
    right_operand = 32'd2;
    in_valid = 1'b1;
    flush = 1'b1;
    tick(1);
    in_valid = 1'b0;
    flush = 1'b0;
    check("t5 flush-offer dropped", 32'(out_valid), 32'd0);
    tick(3);
    // output hold under back-pressure
    out_ready = 1'b0;
    issue(ALU_MUL, 32'h0001_2345, 32'h0000_6789, 1, w);
    wait_out(r);
    for (int i = 0; i < 5; i++) begin
      #2;
      check("t6 hold result", result, model(ALU_MUL, 32'h0001_2345, 32'h0000_6789));
      check("t6 hold valid", 32'(out_valid), 32'd1);
      check("t6 hold in_ready", 32'(in_ready), 32'd0);
      tick(1);
    end
    out_ready = 1'b1;
    tick(2);
    // async reset during BUSY
    issue(ALU_MULHU, ONES, 32'd3, 0, w);
    tick(5);
    reset_n = 1'b0;
    #1;
    check_reset_state("t6 async reset");
    tick(2);
    reset_n = 1'b1;
    tick(40);
    // randomized traffic with random back-pressure
    for (int i = 0; i < 150; i++) begin
      logic [4:0] op;
      logic [31:0] a, b;
      op = 5'($urandom_range(0, 19));
      a = pick();
      b = pick();
      out_ready = $urandom_range(0, 3) != 0;
      issue(op, a, b, 1, w);
      if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
    end
    out_ready = 1'b1;
    tick(40);
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
